// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the iterative divider: width constants,
//               FSM state encodings and two's-complement helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = $clog2(DIV_W) + 1;

  typedef logic [1:0] div_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Two's-complement negation; wraps 0x80000000 onto itself.
  function automatic logic [DIV_W-1:0] div_negate(input logic [DIV_W-1:0] a);
    return ~a + 1'b1;
  endfunction

  // Magnitude of a signed operand, or the raw bits for an unsigned one.
  // The magnitude of the most negative value is 2^(W-1), read as unsigned.
  function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] a,
                                               input logic             is_signed);
    return (is_signed && a[DIV_W-1]) ? div_negate(a) : a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring division iteration (combinational).
//               Shifts the next dividend bit into the partial remainder and
//               subtracts the divisor when it fits.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The compare is WIDTH+1 bits so a shifted remainder above 2^WIDTH-1 is
  // still ordered correctly. When the subtract happens the true difference
  // is below the divisor, so the low WIDTH bits of the modular subtract
  // are exact.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift[WIDTH-1:0] - i_dvs;
    o_qbit  = (w_shift >= {1'b0, i_dvs});
    o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/div_su.sv
`default_nettype none
// ============================================================================
// Module      : div_su
// Description : Iterative signed/unsigned divider, radix-2 restoring, one
//               quotient bit per cycle. Produces quotient and remainder with
//               an in_valid/out_valid handshake; results are held until the
//               next accepted request. A new in_valid aborts any division in
//               progress and restarts with the new operands.
//               Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the
//               iteration phase and finishes on the edge after the load.
// Revision    : 1.0 - initial release
// ============================================================================
module div_su
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             is_signed,
  input  logic             in_valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             out_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;     // dividend magnitude; quotient bits shift in at the LSB
  logic [WIDTH-1:0] r_rem;     // partial remainder
  logic [WIDTH-1:0] r_dvs;     // divisor magnitude
  logic [WIDTH-1:0] r_x;       // raw dividend, returned as remainder on divide-by-zero
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_qbit;
  logic             w_dz;

  assign w_dz = (y == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // Control FSM and datapath: load on in_valid (any state), iterate in CALC,
  // apply sign/zero-divisor correction in FIX, hold results in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_x       <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      q         <= '0;
      r         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1 & 1'b0;
    end else if (in_valid) begin
      r_cnt     <= '0;
      r_dvd     <= div_abs(x, is_signed);
      r_dvs     <= div_abs(y, is_signed);
      r_rem     <= '0;
      r_x       <= x;
      r_neg_q   <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
      r_neg_r   <= is_signed & x[WIDTH-1];
      r_dz      <= w_dz;
      q         <= '0;
      r         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
      r_state   <= w_dz ? ST_FIX : ST_CALC;
`else
      r_state   <= ST_CALC;
`endif
    end else begin
      case (r_state)
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_iter) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          // A zero divisor bypasses sign correction entirely.
          if (r_dz) begin
            q <= '1;
            r <= r_x;
          end else begin
            q <= r_neg_q ? div_negate(r_dvd) : r_dvd;
            r <= r_neg_r ? div_negate(r_rem) : r_rem;
          end
          out_valid <= 1'b1;
          busy      <= 1'b0;
          r_state   <= ST_DONE;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_su.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_su
// Description : Self-checking bench for div_su: directed corner cases, abort,
//               asynchronous reset mid-operation, and randomized operands
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_su;

  logic        clk;
  logic        rst_n;
  logic [31:0] x;
  logic [31:0] y;
  logic        is_signed;
  logic        in_valid;
  logic [31:0] q;
  logic [31:0] r;
  logic        out_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  div_su #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .is_signed (is_signed),
    .in_valid  (in_valid),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division, remainder takes the dividend's sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s,
                                  output logic [31:0] eq, output logic [31:0] er);
    longint sa, sb;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  // Number of clock edges after the accepting edge until out_valid is seen.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return (b == 32'd0) ? 33 : 33;
  endfunction

  // Issue one request and wait (bounded) for its result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] gq, output logic [31:0] gr,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    x = a; y = b; is_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_ok = (busy === 1'b1) && (out_valid === 1'b0) && (q === 32'd0) && (r === 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    gq = q;
    gr = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x = '0; y = '0; is_signed = 1'b0; in_valid = 1'b0;
    #12;
    checks++;
    if ({q, r, out_valid, busy} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state q=%h r=%h ov=%b busy=%b required all zero", q, r, out_valid, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] vx [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000};
    logic [31:0] vy [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                            32'd1, 32'd0, 32'd0, 32'd1};
    logic        vs [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] eq [8] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] er [8] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0,
                            32'd0, 32'd5, 32'd5, 32'd0};
    logic [31:0] gq, gr;
    int lat;
    bit bok;
    for (int i = 0; i < 8; i++) begin
      run_op(vx[i], vy[i], vs[i], gq, gr, lat, bok);
      checks++;
      if (gq !== eq[i] || gr !== er[i]) begin
        errors++;
        $display("FAIL directed_%0d q=%h r=%h required q=%h r=%h", i, gq, gr, eq[i], er[i]);
      end
      checks++;
      if (lat !== exp_lat(vy[i])) begin
        errors++;
        $display("FAIL latency_%0d got %0d edges required %0d", i, lat, exp_lat(vy[i]));
      end
      checks++;
      if (!bok) begin
        errors++;
        $display("FAIL busy_%0d busy/out_valid sequence wrong, final busy=%b required 0", i, busy);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] gq, gr;
    int lat;
    bit bok;
    run_op(32'd1000, 32'd33, 1'b0, gq, gr, lat, bok);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || q !== 32'd30 || r !== 32'd10) begin
      errors++;
      $display("FAIL hold ov=%b q=%0d r=%0d required ov=1 q=30 r=10", out_valid, q, r);
    end
  endtask

  task automatic test_abort();
    int lat;
    @(negedge clk);
    x = 32'd100; y = 32'd7; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    x = 32'd81; y = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL abort_latency got %0d edges required 33", lat);
    end
    checks++;
    if (q !== 32'd9 || r !== 32'd0) begin
      errors++;
      $display("FAIL abort_result q=%0d r=%0d required q=9 r=0", q, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] gq, gr;
    int lat;
    bit bok;
    int seen;
    @(negedge clk);
    x = 32'd100; y = 32'd7; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q, r, out_valid, busy} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid q=%h r=%h ov=%b busy=%b required all zero", q, r, out_valid, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_result got %0d active cycles required 0", seen);
    end
    run_op(32'd81, 32'd9, 1'b0, gq, gr, lat, bok);
    checks++;
    if (gq !== 32'd9 || gr !== 32'd0 || lat !== 33) begin
      errors++;
      $display("FAIL after_reset q=%0d r=%0d lat=%0d required 9 0 33", gq, gr, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq, er, gq, gr;
    logic s;
    int lat;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = 32'($urandom_range(0, 15)) | 32'hFFFF_FFF0;
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      ref_div(a, b, s, eq, er);
      run_op(a, b, s, gq, gr, lat, bok);
      checks++;
      if (gq !== eq || gr !== er || lat !== exp_lat(b) || !bok) begin
        errors++;
        $display("FAIL random_%0d x=%h y=%h s=%b q=%h r=%h lat=%0d busy_ok=%b required q=%h r=%h lat=%0d",
                 i, a, b, s, gq, gr, lat, bok, eq, er, exp_lat(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
